fp_mant_div_seq: RTL
====================

# fp_mant_div_seq

Iterative radix-2 restoring mantissa divider for the single-precision floating-point ALU divide path. It accepts two 24-bit significands (hidden bit included) and returns the 25-bit quotient `floor({a,24'b0} / b)`. This is the same quotient field the divider's exponent/normalisation logic consumes, where `q[24]` selects the normalisation shift. It replaces the combinational 48/24 array with a 25-cycle sequential core behind valid/ready handshakes on both sides.

## Interface
- `W`, default 24: significand width, hidden bit included. The quotient is `W+1` bits. Only 24 is verified.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: operands valid.
- `in_ready`  out  1: core can accept operands.
- `a`  in  24: dividend significand `{hidden, frac[22:0]}`.
- `b`  in  24: divisor significand `{hidden, frac[22:0]}`.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: consumer takes the result.
- `q`  out  25: quotient.
- `dbz`  out  1: divisor was zero.
- `qovf`  out  1: quotient would exceed 25 bits (`a >= 2*b`); `q` is saturated.
- `sticky`  out  1: final remainder is non-zero. Present only with `FP_MANT_DIV_STICKY_EN`.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset puts the FSM in IDLE.
- Reset values: `in_ready`=1, `out_valid`=0, `q`=0, `dbz`=0, `qovf`=0, `sticky`=0. Internal remainder R (25 bits), divisor register, and counter (5 bits) reset to 0.
- IDLE:
  - `in_ready`=1. On `in_valid` the core latches `a`/`b`.
  - If `b==0`: `q`=25'h1FFFFFF, `dbz`=1, go to DONE.
  - Else if `{1'b0,a} >= {b,1'b0}`: `q`=25'h1FFFFFF, `qovf`=1, go to DONE.
  - Else: R=`{1'b0,a}`, counter=24, `q`=0, clear flags, go to BUSY.
- BUSY: one quotient bit per cycle, MSB first.
  - If R>=B: `q[cnt]`=1, R=R−B. Else `q[cnt]`=0.
  - If cnt≠0: R is then shifted left by 1 and cnt decrements.
  - When cnt==0, the iteration completes and the FSM goes to DONE. The final R is not shifted.
- Invariant after bit 24 is resolved: R<B. This guarantees that 2R fits in 25 bits.
- DONE:
  - `out_valid`=1. `q`, `dbz`, `qovf`, `sticky` stay stable until transfer.
  - On `out_ready` the FSM goes to IDLE.
  - `in_ready`=0 in BUSY and DONE, so a new operation is never accepted on the transfer edge.
- `sticky` = (final R ≠ 0). It is 0 when `dbz` or `qovf` is set.
- Denormal divisors (`b[23]`=0, `b`≠0) are legal; large quotients are caught by `qovf`.
- Input changes while not in IDLE have no effect.

## Timing
- Accept edge E0, which needs `in_valid & in_ready`.
- Normal path: iterations at E1..E25, `out_valid` high after E25. Latency is 25 cycles from accept to `out_valid`.
- `dbz`/`qovf` path: `out_valid` high immediately after E0, with no iteration cycles.
- With `out_ready` tied high: the result is taken at E26, `in_ready` is high after E26, and the next accept is at E27. Peak throughput is 1 operation per 27 cycles.
- Backpressure: DONE is held indefinitely and outputs do not change.
- Reset asserted mid-BUSY or mid-DONE: all state clears asynchronously, and the in-flight operation is dropped with no `out_valid`.
- Reset release is synchronous to `clk` (taken care of upstream). The first accept is possible on the first edge after release.

## Configuration
- `FP_MANT_DIV_STICKY_EN` defined: the `sticky` port exists and a remainder non-zero detect is added on the DONE transition. The downstream stage uses it for round-to-nearest-even.
- Not defined: no `sticky` port and no zero-detect logic. The quotient is truncated and the other ports and timing are identical.

## Test plan
- 1.0/1.0: `a`=24'h800000, `b`=24'h800000 → after 25 cycles `q`=25'h1000000, `dbz`=0, `qovf`=0, `sticky`=0.
- 1.0/1.5: `a`=24'h800000, `b`=24'hC00000 → `q`=25'h0AAAAAA, `sticky`=1. 1.5/1.0: `a`=24'hC00000, `b`=24'h800000 → `q`=25'h1800000, `sticky`=0.
- Divide by zero: `b`=0, `a`=24'h800000 → `out_valid` one cycle after accept, `q`=25'h1FFFFFF, `dbz`=1. Overflow: `a`=24'h800000, `b`=24'h000001 → `qovf`=1, `q`=25'h1FFFFFF.
- Backpressure: `out_ready`=0 for 10 cycles after `out_valid` → outputs stable, `in_ready`=0. Then `out_ready`=1 → transfer, and `in_ready`=1 on the next cycle.
- Reset mid-op: assert `rst_n`=0 at iteration 12 → all outputs are at reset values immediately (asynchronous). After release, `in_ready`=1, and a fresh 1.0/1.0 returns `q`=25'h1000000.
- Random: 10k random normal operand pairs plus 1k with `b[23]`=0 against a reference model; random `in_valid`/`out_ready` stalls; no lost or duplicated results.

Source files
------------

// File: rtl/fp_mant_div_seq_if.sv
// rtl/fp_mant_div_seq_if.sv - operand/result handshake bundle for fp_mant_div_seq
// The sticky signal exists only when FP_MANT_DIV_STICKY_EN is defined.
interface fp_mant_div_seq_if #(
  parameter int W = 24
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   q;
  logic         dbz;
  logic         qovf;
`ifdef FP_MANT_DIV_STICKY_EN
  logic         sticky;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, dbz, qovf, sticky
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, dbz, qovf, sticky
  );
`else
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, dbz, qovf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, dbz, qovf
  );
`endif
endinterface

// File: rtl/fp_mant_div_seq.sv
// rtl/fp_mant_div_seq.sv - sequential radix-2 restoring significand divider, q = floor({a,0^W}/b)
// Define FP_MANT_DIV_STICKY_EN to add the remainder-non-zero sticky output.
module fp_mant_div_seq #(
  parameter int W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  fp_mant_div_seq_if.slave  bus
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic [W:0]    q_q;
  logic          dbz_q;
  logic          qovf_q;
  logic [W:0]    rem_q;
  logic [W-1:0]  div_q;
  logic [CW-1:0] cnt_q;
`ifdef FP_MANT_DIV_STICKY_EN
  logic          sticky_q;
`endif

  logic [W+1:0]  diff;
  logic          ge;
  logic [W:0]    rem_d;

  // Trial subtraction; the extra top bit is the borrow, so ge means R >= B.
  always_comb begin
    diff  = {1'b0, rem_q} - {2'b00, div_q};
    ge    = ~diff[W+1];
    rem_d = ge ? diff[W:0] : rem_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      q_q         <= '0;
      dbz_q       <= 1'b0;
      qovf_q      <= 1'b0;
      rem_q       <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
`ifdef FP_MANT_DIV_STICKY_EN
      sticky_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            div_q      <= bus.b;
            in_ready_q <= 1'b0;
            dbz_q      <= 1'b0;
            qovf_q     <= 1'b0;
`ifdef FP_MANT_DIV_STICKY_EN
            sticky_q   <= 1'b0;
`endif
            if (bus.b == '0) begin
              q_q         <= '1;
              dbz_q       <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else if ({1'b0, bus.a} >= {bus.b, 1'b0}) begin
              // Quotient would need W+2 bits; saturate instead of iterating.
              q_q         <= '1;
              qovf_q      <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              rem_q   <= {1'b0, bus.a};
              cnt_q   <= CW'(W);
              q_q     <= '0;
              state_q <= BUSY;
            end
          end
        end

        BUSY: begin
          q_q[cnt_q] <= ge;
          if (cnt_q != '0) begin
            // R < B holds here, so the shifted remainder still fits W+1 bits.
            rem_q <= {rem_d[W-1:0], 1'b0};
            cnt_q <= cnt_q - CW'(1);
          end else begin
            rem_q       <= rem_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
`ifdef FP_MANT_DIV_STICKY_EN
            sticky_q    <= |rem_d;
`endif
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.q         = q_q;
  assign bus.dbz       = dbz_q;
  assign bus.qovf      = qovf_q;
`ifdef FP_MANT_DIV_STICKY_EN
  assign bus.sticky    = sticky_q;
`endif

endmodule
